// File: rtl/time_of_day_counter.sv
// 24-hour hh:mm:ss BCD timekeeping core.
// Advances once per rising edge of an asynchronous 1 Hz square wave and
// supports a set mode where minutes and hours are stepped by user pulses.
module time_of_day_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       sec_clk,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic       tick_1hz,
  output logic       midnight
);

  // Two-digit mod-60 BCD increment; returns {carry, tens, ones}.
  // An out-of-range field wraps straight to 00 and reports a carry.
  function automatic logic [7:0] inc_mod60(input logic [2:0] tens,
                                           input logic [3:0] ones);
    logic [7:0] r;
    if (tens > 3'd5 || ones > 4'd9) begin
      r = {1'b1, 3'd0, 4'd0};
    end else if (ones == 4'd9) begin
      if (tens == 3'd5) r = {1'b1, 3'd0, 4'd0};
      else              r = {1'b0, tens + 3'd1, 4'd0};
    end else begin
      r = {1'b0, tens, ones + 4'd1};
    end
    return r;
  endfunction

  // Hours increment 00..23; returns {wrap, tens, ones}.
  // Any illegal hour (e.g. 24, or ones > 9) wraps to 00.
  function automatic logic [6:0] inc_hours(input logic [1:0] tens,
                                           input logic [3:0] ones);
    logic [6:0] r;
    if (tens > 2'd2 || ones > 4'd9 || (tens == 2'd2 && ones >= 4'd3)) begin
      r = {1'b1, 2'd0, 4'd0};
    end else if (ones == 4'd9) begin
      r = {1'b0, tens + 2'd1, 4'd0};
    end else begin
      r = {1'b0, tens, ones + 4'd1};
    end
    return r;
  endfunction

  localparam int FW = 3;  // fill counter width, enough for SYNC_STAGES up to 4

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   tick_q, tick_d;
  logic                   mid_q, mid_d;
  logic [3:0]             so_q, so_d;
  logic [2:0]             st_q, st_d;
  logic [3:0]             mo_q, mo_d;
  logic [2:0]             mt_q, mt_d;
  logic [3:0]             ho_q, ho_d;
  logic [1:0]             ht_q, ht_d;

  logic       armed;
  logic       synced;
  logic       tick_w;
  logic [7:0] sec_nx;
  logic [7:0] min_nx;
  logic [6:0] hr_nx;

  assign synced = sync_q[SYNC_STAGES-1];
  // The sync chain clears to 0 on reset, so its output briefly reads low
  // even when sec_clk is already high. History is held at 1 until the chain
  // has refilled with real samples; otherwise a wave that was high across
  // reset release would look like a fresh rising edge.
  assign armed  = (fill_q == FW'(SYNC_STAGES));
  assign tick_w = synced & ~hist_q;

  assign sec_nx = inc_mod60(st_q, so_q);
  assign min_nx = inc_mod60(mt_q, mo_q);
  assign hr_nx  = inc_hours(ht_q, ho_q);

  // Edge-detect next state: shift in sec_clk, track history once armed.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sec_clk};
    fill_d = armed ? fill_q : fill_q + FW'(1);
    hist_d = armed ? synced : 1'b1;
    tick_d = tick_w;
  end

  // Time next state: set-mode stepping or normal carry-chain counting.
  always_comb begin
    so_d  = so_q;
    st_d  = st_q;
    mo_d  = mo_q;
    mt_d  = mt_q;
    ho_d  = ho_q;
    ht_d  = ht_q;
    mid_d = 1'b0;
    if (set_en) begin
      // Seconds pinned to 00; minutes and hours step independently, no carry.
      so_d = 4'd0;
      st_d = 3'd0;
      if (inc_min) {mt_d, mo_d} = min_nx[6:0];
      if (inc_hr)  {ht_d, ho_d} = hr_nx[5:0];
    end else if (tick_w) begin
      {st_d, so_d} = sec_nx[6:0];
      if (sec_nx[7]) begin
        {mt_d, mo_d} = min_nx[6:0];
        if (min_nx[7]) begin
          {ht_d, ho_d} = hr_nx[5:0];
          mid_d        = hr_nx[6];
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b1;
      fill_q <= '0;
      tick_q <= 1'b0;
      mid_q  <= 1'b0;
      so_q   <= '0;
      st_q   <= '0;
      mo_q   <= '0;
      mt_q   <= '0;
      ho_q   <= '0;
      ht_q   <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      tick_q <= tick_d;
      mid_q  <= mid_d;
      so_q   <= so_d;
      st_q   <= st_d;
      mo_q   <= mo_d;
      mt_q   <= mt_d;
      ho_q   <= ho_d;
      ht_q   <= ht_d;
    end
  end

  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
  assign hr_ones  = ho_q;
  assign hr_tens  = ht_q;
  assign tick_1hz = tick_q;
  assign midnight = mid_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: time-in-seconds reference model checked
// every cycle, directed scenarios with literal expectations, random phase.
module tb_time_of_day_counter;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_clk = 1'b1;
  logic       set_en = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic [3:0] sec_ones, min_ones, hr_ones;
  logic [2:0] sec_tens, min_tens;
  logic [1:0] hr_tens;
  logic       tick_1hz, midnight;

  time_of_day_counter #(.SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sec_clk(sec_clk), .set_en(set_en),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens),
    .tick_1hz(tick_1hz), .midnight(midnight)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;
  int ticks_seen = 0;
  int mids_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [19:0] pack(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  wire [19:0] dut_time = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  // Reference model: time held as h/m/s integers. A tick is a sec_clk
  // rising edge between two post-reset samples, reported two samples
  // after the first high one (three clk_in cycles after the rise).
  int mh = 0, mm = 0, ms = 0;
  bit etick = 0, emid = 0;
  bit smp[4];
  int nsamp = 0;
  bit model_live = 0;

  always @(posedge clk_in) begin
    if (!rst_n) begin
      mh = 0; mm = 0; ms = 0;
      etick = 0; emid = 0; nsamp = 0;
      model_live = 1;
    end else if (model_live) begin
      smp[3] = smp[2]; smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = sec_clk;
      nsamp++;
      etick = (nsamp >= 4) && !smp[3] && smp[2];
      emid = 0;
      if (set_en) begin
        ms = 0;
        if (inc_min) mm = (mm + 1) % 60;
        if (inc_hr)  mh = (mh + 1) % 24;
      end else if (etick) begin
        int t;
        t = mh * 3600 + mm * 60 + ms + 1;
        if (t == 86400) begin t = 0; emid = 1; end
        mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
      end
    end
    #1;
    if (model_live) begin
      chk("time", 32'(dut_time), 32'(pack(mh, mm, ms)));
      chk("tick_1hz", 32'(tick_1hz), 32'(etick));
      chk("midnight", 32'(midnight), 32'(emid));
      if (tick_1hz === 1'b1) ticks_seen++;
      if (midnight === 1'b1) mids_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_tick();
    sec_clk = 1'b0;
    cyc($urandom_range(1, 3));
    sec_clk = 1'b1;
    cyc($urandom_range(4, 6));
  endtask

  task automatic pulse_min();
    inc_min = 1'b1; cyc(1); inc_min = 1'b0; cyc(1);
  endtask

  task automatic pulse_hr();
    inc_hr = 1'b1; cyc(1); inc_hr = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
  endtask

  // Reset, enter set mode and step to hh:mm; leaves set_en high.
  task automatic set_time(input int h, input int m);
    do_reset();
    set_en = 1'b1; cyc(1);
    repeat (h) pulse_hr();
    repeat (m) pulse_min();
  endtask

  task automatic expect_time(input string name, input int h, input int m, input int s);
    chk(name, 32'(dut_time), 32'(pack(h, m, s)));
  endtask

  initial begin
    int t0, m0;
    // Reset with sec_clk already high; no tick until it drops and rises.
    cyc(3);
    expect_time("reset_time", 0, 0, 0);
    chk("reset_tick", 32'(tick_1hz), 32'd0);
    chk("reset_mid", 32'(midnight), 32'd0);
    rst_n = 1'b1;
    cyc(10);
    chk("no_tick_high_at_release", 32'(ticks_seen), 32'd0);
    sec_clk = 1'b0; cyc(2);
    sec_clk = 1'b1; cyc(5);
    chk("first_tick_count", 32'(ticks_seen), 32'd1);
    expect_time("first_tick_time", 0, 0, 1);

    // Seconds carry into minutes.
    set_time(0, 0);
    set_en = 1'b0; cyc(1);
    repeat (59) do_tick();
    expect_time("at_00_00_59", 0, 0, 59);
    t0 = ticks_seen; m0 = mids_seen;
    do_tick();
    expect_time("carry_00_01_00", 0, 1, 0);
    chk("carry_tick_once", 32'(ticks_seen - t0), 32'd1);
    chk("carry_no_mid", 32'(mids_seen - m0), 32'd0);

    // Midnight rollover.
    set_time(23, 59);
    set_en = 1'b0; cyc(1);
    m0 = mids_seen;
    repeat (59) do_tick();
    expect_time("at_23_59_59", 23, 59, 59);
    do_tick();
    expect_time("midnight_00_00_00", 0, 0, 0);
    chk("midnight_once", 32'(mids_seen - m0), 32'd1);

    // Set-mode wraps and simultaneous increments.
    set_time(0, 59);
    pulse_min();
    expect_time("min_wrap", 0, 0, 0);
    repeat (23) pulse_hr();
    expect_time("at_23_00", 23, 0, 0);
    pulse_hr();
    expect_time("hr_wrap", 0, 0, 0);
    set_time(12, 30);
    inc_min = 1'b1; inc_hr = 1'b1; cyc(1);
    inc_min = 1'b0; inc_hr = 1'b0; cyc(1);
    expect_time("both_inc", 13, 31, 0);
    set_en = 1'b0;
    pulse_min(); pulse_hr();
    expect_time("inc_ignored_normal", 13, 31, 0);

    // Set-mode freeze.
    set_time(10, 20);
    set_en = 1'b0; cyc(1);
    repeat (45) do_tick();
    expect_time("at_10_20_45", 10, 20, 45);
    set_en = 1'b1; cyc(1);
    expect_time("freeze_sec0", 10, 20, 0);
    t0 = ticks_seen;
    repeat (5) do_tick();
    expect_time("freeze_hold", 10, 20, 0);
    chk("freeze_ticks", 32'(ticks_seen - t0), 32'd5);
    set_en = 1'b0; cyc(1);
    do_tick();
    expect_time("resume", 10, 20, 1);

    // Reset coincident with a tick.
    set_time(7, 15);
    set_en = 1'b0; cyc(1);
    repeat (33) do_tick();
    expect_time("at_07_15_33", 7, 15, 33);
    sec_clk = 1'b0; cyc(3);
    sec_clk = 1'b1; cyc(2);
    rst_n = 1'b0; cyc(1);
    expect_time("reset_midrun", 0, 0, 0);
    chk("reset_midrun_tick", 32'(tick_1hz), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    expect_time("after_reset_midrun", 0, 0, 0);

    // Random phase; the model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) sec_clk = ~sec_clk;
      if ($urandom_range(0, 29) == 0) set_en = ~set_en;
      inc_min = ($urandom_range(0, 5) == 0);
      inc_hr  = ($urandom_range(0, 7) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    rst_n = 1'b1; inc_min = 1'b0; inc_hr = 1'b0; set_en = 1'b0;
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- 24-hour hh:mm:ss timekeeping core for the multimode clock.
- Consumes the 1 Hz square wave from the clock divider stage and advances a BCD time register once per rising edge of that wave.
- Supports a set mode in which minutes and hours are stepped by user pulses.
- BCD digit outputs feed the seven-segment display mux directly.

Parameters:
SYNC_STAGES, 2, number of flip-flops synchronising sec_clk into the clk_in domain (legal 2..4).

Ports:
clk_in  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  synchronous reset, active-low.
sec_clk  input  1  1 Hz square wave from the divider stage; asynchronous to any phase of clk_in.
set_en  input  1  high = set mode; time frozen, manual stepping enabled.
inc_min  input  1  one-clk_in-cycle pulse (already debounced); step minutes in set mode.
inc_hr  input  1  one-clk_in-cycle pulse (already debounced); step hours in set mode.
sec_ones  output  4  BCD seconds units, 0..9.
sec_tens  output  3  BCD seconds tens, 0..5.
min_ones  output  4  BCD minutes units, 0..9.
min_tens  output  3  BCD minutes tens, 0..5.
hr_ones  output  4  BCD hours units, 0..9 (0..3 when hr_tens=2).
hr_tens  output  2  BCD hours tens, 0..2.
tick_1hz  output  1  one-cycle pulse on each detected sec_clk rising edge, regardless of mode.
midnight  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset: rst_n sampled low at a clk_in edge -> all digits 0 (00:00:00), tick_1hz=0, midnight=0, sync chain cleared to 0, edge-history register set to 1. Reset mid-count is honoured on the next edge; no partial update.
- Edge detect:
  - sec_clk passes through SYNC_STAGES flops, then one history flop.
  - tick = synced & ~history.
  - Because history resets to 1, a sec_clk already high at reset release produces no tick; the first tick requires a low-then-high transition.
  - tick_1hz is registered and asserts SYNC_STAGES+1 clk_in cycles after the sec_clk rising edge (3 cycles at default).
  - Exactly one tick per sec_clk rising edge.
- Normal mode (set_en=0), on each internal tick:
  - Seconds increment in BCD: ones 9->0 carries to tens; tens 5 with ones 9 -> 00 and carry to minutes.
  - Minutes use the same scheme; 59 -> 00 carries to hours.
  - Hours: ones 9->0 carries to tens; 23 -> 00 wraps.
  - Digit registers update in the same cycle that tick_1hz is registered high.
  - midnight is registered high in the same cycle that the digits become 00:00:00 from 23:59:59.
  - inc_min and inc_hr are ignored in normal mode.
- Set mode (set_en=1):
  - Seconds forced to 00 on every cycle set_en is high.
  - Ticks do not advance time; tick_1hz still pulses.
  - inc_min: minutes +1, 59 -> 00, no carry into hours.
  - inc_hr: hours +1, 23 -> 00.
  - midnight never asserts in set mode.
  - inc_min and inc_hr high in the same cycle: both apply independently in that cycle.
  - Increments take effect on the clk_in edge that samples the pulse; the digit outputs show the new value the following cycle.
  - A pulse held high N cycles steps N times; upstream guarantees single-cycle pulses.
- Leaving set mode: set_en falls -> counting resumes from hh:mm:00 at the next tick. A tick in the same cycle set_en is sampled 0 advances to hh:mm:01.
- Simultaneous events:
  - set_en=1 with a tick: the tick is ignored for timekeeping.
  - Reset dominates every other input.
- All outputs are registered; no combinational path from any input to any output.
- Digits never hold illegal BCD values. Any illegal value, e.g. 24 hours, is unreachable; if it is forced in simulation, the next increment wraps that field to 0.

Test Plan:
- Reset/first edge: hold sec_clk=1 through reset release, keep it high 10 cycles, then drop and raise it -> no tick before the drop. After the rise, tick_1hz pulses once 3 cycles later and the time reads 00:00:01.
- Seconds carry: preload 00:00:59 via set mode at 00:00, then 59 ticks -> next tick gives 00:01:00 with the single tick_1hz pulse and midnight=0.
- Midnight rollover: set to 23:59 (23 inc_hr pulses, 59 inc_min pulses), release set_en, apply 60 ticks -> 23:59:59 then 00:00:00. midnight pulses exactly one cycle, aligned with the 00:00:00 digits.
- Set-mode wrap: in set mode at 00:59, pulse inc_min -> 00:00 (hours unchanged). At 23:00, pulse inc_hr -> 00:00. Pulse inc_min and inc_hr together at 12:30 -> 13:31.
- Set-mode freeze: at 10:20:45, raise set_en -> seconds read 00 next cycle. Apply 5 ticks -> time stays 10:20:00 and tick_1hz pulses 5 times. Lower set_en, apply 1 tick -> 10:20:01.
- Reset mid-run: at 07:15:33, assert rst_n=0 for 1 cycle coincident with a tick -> 00:00:00 and no tick_1hz pulse in that cycle.
